// File: rtl/atk16_pkg.sv
// Shared definitions for the memory-side bus controller: MMIO register map,
// controller states and address-decode targets.
package atk16_pkg;

  localparam logic [15:0] MMIO_GPIO_OUT  = 16'hFF00;
  localparam logic [15:0] MMIO_GPIO_IN   = 16'hFF01;
  localparam logic [15:0] MMIO_TIMER_CNT = 16'hFF02;
  localparam logic [15:0] MMIO_TIMER_CMP = 16'hFF03;
  localparam logic [15:0] MMIO_STATUS    = 16'hFF04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BWAIT = 2'd1,
    ACK   = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    T_BRAM = 2'd0,
    T_MMIO = 2'd1,
    T_NONE = 2'd2
  } target_e;

  function automatic target_e decode_target(input logic [15:0] a, input int unsigned bram_words);
    target_e t;
    if (32'(a) < bram_words) begin
      t = T_BRAM;
    end else if ((a >= MMIO_GPIO_OUT) && (a <= MMIO_STATUS)) begin
      t = T_MMIO;
    end else begin
      t = T_NONE;
    end
    return t;
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Control-unit to memory-controller request/acknowledge bus.
interface mem_bus_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mmio_timer.sv
// Prescaled 16-bit timer with compare register and sticky match flag.
// A count write restarts the prescaler and suppresses that cycle's compare.
module mmio_timer
  import atk16_pkg::*;
#(
  parameter int unsigned PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic        stat_we_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] cnt_o,
  output logic [15:0] cmp_o,
  output logic        flag_o
);

  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PSC_ONE = PW'(1);

  logic [PW-1:0] psc_q, psc_d;
  logic [15:0]   cnt_q, cnt_d, cmp_q, cmp_d;
  logic          flag_q, flag_d;
  logic          tick_s, match_s;

  // Next-state: prescaler wrap, count/compare update, flag set-over-clear.
  always_comb begin
    tick_s  = (psc_q == PSC_MAX);
    psc_d   = tick_s ? {PW{1'b0}} : (psc_q + PSC_ONE);
    cnt_d   = cnt_q;
    match_s = 1'b0;
    if (cnt_we_i) begin
      cnt_d = wdata_i;
      psc_d = {PW{1'b0}};
    end else if (tick_s) begin
      cnt_d   = cnt_q + 16'd1;
      match_s = (cnt_d == cmp_q);
    end else begin
      cnt_d = cnt_q;
    end
    cmp_d = cmp_we_i ? wdata_i : cmp_q;
    if (match_s) begin
      flag_d = 1'b1;
    end else if (stat_we_i && wdata_i[0]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q  <= {PW{1'b0}};
      cnt_q  <= 16'h0000;
      cmp_q  <= 16'h0000;
      flag_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: one request at a time, decoded to BRAM or the
// GPIO/timer window, with BRAM read latency hidden behind a uniform ack.
module mem_bus_ctrl
  import atk16_pkg::*;
#(
  parameter int unsigned BRAM_WORDS = 4096,
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned GPIO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_if.slave          bus,
  output logic [15:0]       bram_addr,
  output logic              bram_we,
  output logic [15:0]       bram_wdata,
  input  logic [15:0]       bram_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  bus_state_e        state_q;
  target_e           tgt_q, tgt_s;
  logic [15:0]       addr_q, wdata_q, bram_hold_q, rdata_q, mmio_rd_s;
  logic              we_q, ack_q, err_q, mmio_wr_s;
  logic [GPIO_W-1:0] gpio_q, sync1_q, sync2_q;
  logic [15:0]       tcnt_s, tcmp_s;
  logic              tflag_s;

  assign tgt_s      = decode_target(bus.addr, BRAM_WORDS);
  assign bram_addr  = bus.addr;
  assign bram_wdata = bus.wdata;
  assign bram_we    = (state_q == IDLE) && bus.req && bus.we && (tgt_s == T_BRAM);

  // MMIO stores land on the edge that leaves ACK, using the latched request.
  assign mmio_wr_s = (state_q == ACK) && we_q && (tgt_q == T_MMIO);

  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .cnt_we_i  (mmio_wr_s && (addr_q == MMIO_TIMER_CNT)),
    .cmp_we_i  (mmio_wr_s && (addr_q == MMIO_TIMER_CMP)),
    .stat_we_i (mmio_wr_s && (addr_q == MMIO_STATUS)),
    .wdata_i   (wdata_q),
    .cnt_o     (tcnt_s),
    .cmp_o     (tcmp_s),
    .flag_o    (tflag_s)
  );

  // MMIO read mux on the latched address.
  always_comb begin
    mmio_rd_s = 16'h0000;
    case (addr_q)
      MMIO_GPIO_OUT:  mmio_rd_s = 16'(gpio_q);
      MMIO_GPIO_IN:   mmio_rd_s = 16'(sync2_q);
      MMIO_TIMER_CNT: mmio_rd_s = tcnt_s;
      MMIO_TIMER_CMP: mmio_rd_s = tcmp_s;
      MMIO_STATUS:    mmio_rd_s = {15'd0, tflag_s};
      default:        mmio_rd_s = 16'h0000;
    endcase
  end

  // Two-flop synchroniser for the asynchronous GPIO pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= {GPIO_W{1'b0}};
      sync2_q <= {GPIO_W{1'b0}};
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Request FSM with registered ack/err/rdata and the GPIO output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tgt_q       <= T_BRAM;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      bram_hold_q <= 16'h0000;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      gpio_q      <= {GPIO_W{1'b0}};
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            tgt_q   <= tgt_s;
            state_q <= ((tgt_s == T_BRAM) && !bus.we) ? BWAIT : ACK;
          end else begin
            state_q <= IDLE;
          end
        end
        BWAIT: begin
          bram_hold_q <= bram_rdata;
          state_q     <= ACK;
        end
        ACK: begin
          ack_q <= 1'b1;
          err_q <= (tgt_q == T_NONE);
          if (we_q) begin
            rdata_q <= 16'h0000;
          end else begin
            case (tgt_q)
              T_BRAM:  rdata_q <= bram_hold_q;
              T_MMIO:  rdata_q <= mmio_rd_s;
              default: rdata_q <= 16'h0000;
            endcase
          end
          if (mmio_wr_s && (addr_q == MMIO_GPIO_OUT)) begin
            gpio_q <= wdata_q[GPIO_W-1:0];
          end else begin
            gpio_q <= gpio_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign gpio_out  = gpio_q;
  assign irq       = tflag_s;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a transaction-level reference model checked
// every cycle, plus literal expectations on each directed access.
module tb_mem_bus_ctrl;

  localparam int BW = 4096;
  localparam int PS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bram_addr, bram_wdata, bram_rdata;
  logic        bram_we;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        irq;

  mem_bus_if bus();

  mem_bus_ctrl #(.BRAM_WORDS(BW), .PRESCALE(PS), .GPIO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle synchronous read.
  logic [15:0] ram [0:BW-1];
  initial for (int i = 0; i < BW; i++) ram[i] = 16'h0000;
  always @(posedge clk) begin
    if (bram_we) ram[bram_addr[11:0]] <= bram_wdata;
    bram_rdata <= ram[bram_addr[11:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int          m_left = 0;
  int          m_psc = 0;
  logic        m_ack = 1'b0, m_err = 1'b0, m_load = 1'b0, m_flag = 1'b0;
  logic [15:0] m_rdata = 16'h0, m_cnt = 16'h0, m_cmp = 16'h0;
  logic [7:0]  m_gpio = 8'h0, m_s1 = 8'h0, m_s2 = 8'h0;
  logic [15:0] t_addr = 16'h0, t_wd = 16'h0, t_bram = 16'h0;
  logic        t_we = 1'b0;
  logic [15:0] m_mem [0:BW-1];
  initial for (int i = 0; i < BW; i++) m_mem[i] = 16'h0000;

  function automatic logic is_mapped(input logic [15:0] a);
    return (int'(a) < BW) || (a >= 16'hFF00 && a <= 16'hFF04);
  endfunction

  task model_step();
    logic tick, match, w_cnt, w_cmp, w_stat, w_gpio;
    if (!rst) begin
      m_left = 0; m_ack = 0; m_err = 0; m_load = 0; m_rdata = 0;
      m_gpio = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_cmp = 0; m_psc = 0; m_flag = 0;
    end else begin
      w_cnt = 0; w_cmp = 0; w_stat = 0; w_gpio = 0;
      m_ack = 0; m_err = 0; m_load = 0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ack  = 1;
          m_load = !t_we;
          m_err  = !is_mapped(t_addr);
          if (!t_we) begin
            if (int'(t_addr) < BW) m_rdata = t_bram;
            else case (t_addr)
              16'hFF00: m_rdata = {8'h00, m_gpio};
              16'hFF01: m_rdata = {8'h00, m_s2};
              16'hFF02: m_rdata = m_cnt;
              16'hFF03: m_rdata = m_cmp;
              16'hFF04: m_rdata = {15'd0, m_flag};
              default:  m_rdata = 16'h0000;
            endcase
          end else begin
            w_gpio = (t_addr == 16'hFF00);
            w_cnt  = (t_addr == 16'hFF02);
            w_cmp  = (t_addr == 16'hFF03);
            w_stat = (t_addr == 16'hFF04);
          end
        end
      end else if (bus.req) begin
        t_addr = bus.addr; t_we = bus.we; t_wd = bus.wdata;
        if (int'(t_addr) < BW && t_we) begin
          m_mem[t_addr[11:0]] = t_wd; m_left = 1;
        end else if (int'(t_addr) < BW) begin
          t_bram = m_mem[t_addr[11:0]]; m_left = 2;
        end else begin
          m_left = 1;
        end
      end
      tick  = (m_psc == PS - 1);
      m_psc = tick ? 0 : m_psc + 1;
      match = 0;
      if (w_cnt) begin
        m_cnt = t_wd; m_psc = 0;
      end else if (tick) begin
        m_cnt = m_cnt + 16'd1;
        match = (m_cnt == m_cmp);
      end
      if (w_cmp) m_cmp = t_wd;
      if (match) m_flag = 1;
      else if (w_stat && t_wd[0]) m_flag = 0;
      if (w_gpio) m_gpio = t_wd[7:0];
      m_s2 = m_s1;
      m_s1 = gpio_in;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {15'd0, bus.ack}, {15'd0, m_ack});
      check("err", {15'd0, bus.err}, {15'd0, m_err});
      if (m_ack && m_load) check("rdata", bus.rdata, m_rdata);
      check("gpio_out", {8'h00, gpio_out}, {8'h00, m_gpio});
      check("irq", {15'd0, irq}, {15'd0, m_flag});
    end
  end

  // One bus access with literal expectations on data, err and ack latency.
  task automatic op(input string nm, input logic w, input logic [15:0] a, input logic [15:0] d,
                    input logic [15:0] exp_rd, input logic exp_er, input int exp_lat);
    int cyc;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack !== 1'b1 && cyc < 16);
    check({nm, ".ack"}, {15'd0, bus.ack}, 16'd1);
    check({nm, ".err"}, {15'd0, bus.err}, {15'd0, exp_er});
    check({nm, ".lat"}, 16'(cyc - 1), 16'(exp_lat));
    if (!w) check({nm, ".rdata"}, bus.rdata, exp_rd);
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0; bus.wdata = 16'h0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_gpio", {8'h00, gpio_out}, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_ack", {15'd0, bus.ack}, 16'h0000);

    op("st_bram",  1'b1, 16'h0064, 16'hBEEF, 16'h0000, 1'b0, 1);
    op("ld_bram",  1'b0, 16'h0064, 16'h0000, 16'hBEEF, 1'b0, 2);
    op("st_top",   1'b1, 16'h0FFF, 16'h5A5A, 16'h0000, 1'b0, 1);
    op("ld_top",   1'b0, 16'h0FFF, 16'h0000, 16'h5A5A, 1'b0, 2);
    op("st_zero",  1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 1);
    op("st_unmap", 1'b1, 16'hF000, 16'hDEAD, 16'h0000, 1'b1, 1);
    op("ld_unmap", 1'b0, 16'hF000, 16'h0000, 16'h0000, 1'b1, 1);
    op("ld_1000",  1'b0, 16'h1000, 16'h0000, 16'h0000, 1'b1, 1);
    op("ld_ff05",  1'b0, 16'hFF05, 16'h0000, 16'h0000, 1'b1, 1);
    op("ld_zero",  1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 2);

    op("st_gpio",  1'b1, 16'hFF00, 16'h00A5, 16'h0000, 1'b0, 1);
    check("gpio_a5", {8'h00, gpio_out}, 16'h00A5);
    op("ld_gpo",   1'b0, 16'hFF00, 16'h0000, 16'h00A5, 1'b0, 1);
    gpio_in = 8'h3C;
    repeat (2) @(negedge clk);
    op("ld_gpi",   1'b0, 16'hFF01, 16'h0000, 16'h003C, 1'b0, 1);
    op("st_gpi",   1'b1, 16'hFF01, 16'hFFFF, 16'h0000, 1'b0, 1);

    op("st_cnt0",  1'b1, 16'hFF02, 16'h0000, 16'h0000, 1'b0, 1);
    op("st_cmp5",  1'b1, 16'hFF03, 16'h0005, 16'h0000, 1'b0, 1);
    check("irq_pre", {15'd0, irq}, 16'h0000);
    repeat (8) @(negedge clk);
    check("irq_match", {15'd0, irq}, 16'h0001);
    op("ld_cnt5",  1'b0, 16'hFF02, 16'h0000, 16'h0005, 1'b0, 1);
    op("ld_stat1", 1'b0, 16'hFF04, 16'h0000, 16'h0001, 1'b0, 1);
    op("w1c",      1'b1, 16'hFF04, 16'h0001, 16'h0000, 1'b0, 1);
    check("irq_clr", {15'd0, irq}, 16'h0000);
    op("ld_stat0", 1'b0, 16'hFF04, 16'h0000, 16'h0000, 1'b0, 1);
    op("st_ffff",  1'b1, 16'hFF02, 16'hFFFF, 16'h0000, 1'b0, 1);
    @(negedge clk);
    op("ld_wrap",  1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b0, 1);

    op("st_cnt3",  1'b1, 16'hFF02, 16'h0003, 16'h0000, 1'b0, 1);
    repeat (2) @(negedge clk);
    op("w1c_coll", 1'b1, 16'hFF04, 16'h0001, 16'h0000, 1'b0, 1);
    op("st_1234",  1'b1, 16'hFF02, 16'h1234, 16'h0000, 1'b0, 1);
    op("ld_1234",  1'b0, 16'hFF02, 16'h0000, 16'h1234, 1'b0, 1);
    check("irq_coll", {15'd0, irq}, 16'h0001);
    op("ld_stat_c", 1'b0, 16'hFF04, 16'h0000, 16'h0001, 1'b0, 1);

    // Reset while the load sits in BWAIT; the request must vanish.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0064;
    @(posedge clk); #2 rst = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    check("mid_ack", {15'd0, bus.ack}, 16'h0000);
    check("mid_gpio", {8'h00, gpio_out}, 16'h0000);
    check("mid_irq", {15'd0, irq}, 16'h0000);
    repeat (2) @(negedge clk);
    check("mid_ack2", {15'd0, bus.ack}, 16'h0000);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    op("ld_again", 1'b0, 16'h0064, 16'h0000, 16'hBEEF, 1'b0, 2);
    op("ld_cmp0",  1'b0, 16'hFF03, 16'h0000, 16'h0000, 1'b0, 1);
    op("ld_stat_r", 1'b0, 16'hFF04, 16'h0000, 16'h0000, 1'b0, 1);
    op("ld_gpo_r", 1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b0, 1);
    op("ld_gpi_r", 1'b0, 16'hFF01, 16'h0000, 16'h003C, 1'b0, 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory-side bus controller between the control unit and the block RAM. Accepts one load/store request at a time from the CU over a req/ack handshake and decodes the 16-bit word address to either BRAM or a small memory-mapped peripheral window. The window holds GPIO and a prescaled 16-bit timer with a compare flag. Absorbs the BRAM's one-cycle read latency, so the CU sees a uniform handshake for every target.

## Interface
- `BRAM_WORDS`, 4096: BRAM depth in 16-bit words; mapped at 0x0000..BRAM_WORDS-1.
- `PRESCALE`, 100: clk cycles per timer tick; minimum 1.
- `GPIO_W`, 8: GPIO width.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: CU request; held with addr/we/wdata until `ack`.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 16: word address.
- `wdata` in 16: store data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 16: load data; valid while `ack` = 1.
- `err` out 1: pulses with `ack` when the address is unmapped.
- `bram_addr` out 16: BRAM address.
- `bram_we` out 1: BRAM write enable.
- `bram_wdata` out 16: BRAM write data.
- `bram_rdata` in 16: BRAM synchronous read data, valid one cycle after the address edge.
- `gpio_in` in GPIO_W: asynchronous inputs.
- `gpio_out` out GPIO_W: output register.
- `irq` out 1: level; equals STATUS[0].

## Operation
- Address map:
  - 0x0000..BRAM_WORDS-1: BRAM.
  - 0xFF00: GPIO_OUT, read/write.
  - 0xFF01: GPIO_IN, read-only, 2-flop synchronised.
  - 0xFF02: TIMER_CNT, read/write.
  - 0xFF03: TIMER_CMP, read/write.
  - 0xFF04: STATUS; bit0 = match flag, write-1-to-clear; other bits read 0.
  - Narrow registers zero-extend on read and use the low bits on write.
  - Any other address is unmapped: read returns 0x0000, write is dropped, `err`=1 with `ack`.
- FSM states:
  - IDLE: if `req`, decode. BRAM read → BWAIT. All other accesses perform the action → ACK.
  - BWAIT: latch `bram_rdata` → ACK.
  - ACK: `ack`=1 → IDLE. A request is never accepted in the ACK cycle.
- `bram_addr` = `addr` combinationally. `bram_we` = IDLE & `req` & `we` & in-BRAM-range. `bram_wdata` = `wdata`.
- Writes to read-only GPIO_IN complete normally, without `err`.
- Timer:
  - A prescaler counter 0..PRESCALE-1 advances every cycle. On wrap, TIMER_CNT increments modulo 2^16 (0xFFFF → 0x0000).
  - When the incremented TIMER_CNT equals TIMER_CMP, STATUS[0] sets.
  - Writing TIMER_CNT also clears the prescaler.
- Simultaneous events:
  - CPU write to TIMER_CNT in the same cycle as a tick: the write wins and no compare check is made that cycle.
  - Match and a W1C on STATUS in the same cycle: the set wins.
- Reset (async, any state, including mid-transaction): FSM → IDLE. `ack`, `err`, `rdata`, `gpio_out`, TIMER_CNT, TIMER_CMP, prescaler, STATUS and the sync flops all go to 0. An interrupted request gets no `ack`; the CU must reissue it.

## Timing
- `req` sampled at edge N while in IDLE.
- Completion latency:
  - BRAM read: `ack` high after edge N+2.
  - All other accesses: `ack` high after edge N+1.
- `ack`, `rdata` and `err` are registered and high for exactly one cycle.
- The CU must drop `req` in the cycle following `ack`, or a new transaction starts at the next IDLE edge.
- Back-to-back throughput:
  - BRAM read: one access per 3 cycles.
  - Other accesses: one access per 2 cycles.
- GPIO_IN reflects a pin change after 2 edges, plus the access latency.
- Store visibility:
  - `gpio_out` and timer registers update at edge N+1.
  - BRAM is written at edge N.

## Structure
- Shared package `atk16_pkg`:
  - Address constants MMIO_GPIO_OUT … MMIO_STATUS.
  - The FSM state enum (IDLE/BWAIT/ACK).
  - The address-decode target enum (T_BRAM/T_MMIO/T_NONE).
- One sub-module, `mmio_timer`: prescaler, TIMER_CNT/TIMER_CMP, match flag and W1C.
  - Inputs: write strobes and write data.
  - Outputs: cnt, cmp and flag.
- Decode, FSM, GPIO and read mux stay in `mem_bus_ctrl`.

## Test plan
- BRAM store then load: preload nothing, store 0xBEEF to 0x0064, then load 0x0064 → `rdata`=0xBEEF. `ack` arrives 1 edge after the store request and 2 edges after the load request; `err`=0.
- GPIO: store 0x00A5 to 0xFF00 → `gpio_out`=0xA5. Drive `gpio_in`=0x3C, wait 2 cycles, load 0xFF01 → 0x003C.
- Timer, with PRESCALE=2:
  - Write CMP=5 and CNT=0; after 10 cycles CNT=5, STATUS=1 and `irq`=1.
  - Write STATUS=1 → STATUS=0 and `irq`=0.
  - With CNT=0xFFFF, one tick later CNT=0x0000.
- Unmapped: load 0xF000 with BRAM_WORDS=4096 → `rdata`=0, `err`=1 for one cycle. A store to 0xF000 changes no state.
- Collisions:
  - W1C on STATUS issued in the exact match cycle → STATUS stays 1.
  - TIMER_CNT write of 0x1234 coincident with a tick → CNT=0x1234.
- Reset mid-operation: assert `rst`=0 while in BWAIT → no `ack`, FSM in IDLE, all registers 0. A reissued load after reset completes normally.
